// File: rtl/adder_phase_pkg.sv
// Shared types and step arithmetic for the 8-phase adiabatic adder driver.
// The bit-order helpers map LSB-first [0:N-1] adder buses to [N-1:0] host words.
package adder_phase_pkg;

    localparam int NUM_PHASES = 8;
    localparam int DATA_W     = 16;

    typedef enum logic {IDLE, RUN} state_t;

    // Last step of an operation: the final phase has just come up and is held.
    function automatic int last_step(input int hold);
        return NUM_PHASES - 2 + hold;
    endfunction

    // Last step where the two final phases overlap, so the adder output is valid.
    function automatic int cap_step(input int hold);
        return NUM_PHASES - 3 + hold;
    endfunction

    function automatic logic [0:DATA_W-1] to_lsb0(input logic [DATA_W-1:0] v);
        logic [0:DATA_W-1] r;
        for (int i = 0; i < DATA_W; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] from_lsb0(input logic [0:DATA_W-1] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = v[i];
        return r;
    endfunction

endpackage

// File: rtl/adiabatic_phase_gen.sv
// Registered overlapping power-clock generator: phase k is high for steps
// k..k+HOLD-1 while running. Fed with next-cycle step/run so outputs align.
module adiabatic_phase_gen
    import adder_phase_pkg::*;
#(
    parameter int NUM    = NUM_PHASES,
    parameter int HOLD   = 2,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STEP_W-1:0] step,
    input  logic              run,
    output logic [0:NUM-1]    clkpos,
    output logic [0:NUM-1]    clkneg
);

    logic [0:NUM-1] pos_next;

    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            pos_next[k] = run && (int'(step) >= k) && (int'(step) <= k + HOLD - 1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous
    // so the phases collapse to idle the instant rst rises, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkpos <= '0;
            clkneg <= '1;
        end else begin
            clkpos <= pos_next;
            clkneg <= ~pos_next;
        end
    end

endmodule

// File: rtl/adder_phase_driver.sv
// Host-side initiator for the 16-bit 8-phase adiabatic adder: launches one
// operation per request, sequences the phases, captures and returns the result.
module adder_phase_driver
    import adder_phase_pkg::*;
#(
    parameter int STEP_CYCLES = 2,
    parameter int HOLD_STEPS  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [DATA_W-1:0]      req_a,
    input  logic [DATA_W-1:0]      req_b,
    input  logic                   req_cin,
    input  logic                   req_sub,
    output logic [0:DATA_W-1]      add_a,
    output logic [0:DATA_W-1]      add_b,
    output logic                   add_cin,
    output logic [0:NUM_PHASES-1]  clkpos,
    output logic [0:NUM_PHASES-1]  clkneg,
    input  logic [0:DATA_W-1]      add_out,
    input  logic                   add_cout,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_ovf
);

    localparam int LAST   = last_step(HOLD_STEPS);
    localparam int CAP    = cap_step(HOLD_STEPS);
    localparam int STEP_W = $clog2(LAST + 1);
    localparam int CYC_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              launch, cyc_last, capture;

    assign req_ready = !rst && (state_q == IDLE) && (!rsp_valid || rsp_ready);
    assign launch    = req_valid && req_ready;
    assign cyc_last  = (cyc_q == CYC_W'(STEP_CYCLES - 1));
    assign capture   = (state_q == RUN) && (step_q == STEP_W'(CAP)) && cyc_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            step_q  <= step_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = RUN;
                    cyc_d   = '0;
                    step_d  = '0;
                end
            end
            RUN: begin
                if (cyc_last) begin
                    cyc_d = '0;
                    if (step_q == STEP_W'(LAST)) begin
                        state_d = IDLE;
                        step_d  = '0;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands stay on the adder inputs until the next launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else if (launch) begin
            add_a   <= to_lsb0(req_a);
            add_b   <= to_lsb0(req_sub ? ~req_b : req_b);
            add_cin <= req_sub | req_cin;
        end
    end

    // add_b already holds the effective (inverted for sub) operand, so its MSB
    // is the overflow term for both add and subtract.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= from_lsb0(add_out);
            rsp_cout  <= add_cout;
            rsp_ovf   <= (add_a[DATA_W-1] == add_b[DATA_W-1]) &&
                         (add_out[DATA_W-1] != add_a[DATA_W-1]);
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    adiabatic_phase_gen #(
        .NUM    (NUM_PHASES),
        .HOLD   (HOLD_STEPS),
        .STEP_W (STEP_W)
    ) u_phase_gen (
        .clk    (clk),
        .rst    (rst),
        .step   (step_d),
        .run    (state_d == RUN),
        .clkpos (clkpos),
        .clkneg (clkneg)
    );

endmodule

// File: tb/tb_adder_phase_driver.sv
// Scoreboard bench for adder_phase_driver with a behavioural adiabatic adder
// whose output is only correct while phases 6 and 7 overlap.
module tb_adder_phase_driver;
    import adder_phase_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_cin, req_sub;
    logic [15:0] req_a, req_b;
    logic [0:15] add_a, add_b, add_out;
    logic        add_cin, add_cout;
    logic [0:7]  clkpos, clkneg;
    logic        rsp_valid, rsp_ready, rsp_cout, rsp_ovf;
    logic [15:0] rsp_sum;

    always #5 clk = ~clk;

    adder_phase_driver dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .clkpos(clkpos), .clkneg(clkneg),
        .add_out(add_out), .add_cout(add_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
    );

    // Adder model: garbage (inverted result) unless the final two phases overlap.
    logic [15:0] ma, mb, ms;
    logic        mc;
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ma[i] = add_a[i];
            mb[i] = add_b[i];
        end
        {mc, ms} = {1'b0, ma} + {1'b0, mb} + {16'd0, add_cin};
        if (!(clkpos[6] && clkpos[7])) begin
            ms = ~ms;
            mc = ~mc;
        end
        for (int i = 0; i < 16; i++) add_out[i] = ms[i];
        add_cout = mc;
    end

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          hs;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc_cnt = 0;
    int          cur_hs = -1000;
    int          prev_hs = -1000;
    logic [15:0] cur_a, cur_b;
    logic        cur_cin;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: latency on first sight of rsp_valid, values on handshake.
    initial begin
        exp_t e;
        logic seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else begin
                if (rsp_valid && !seen) begin
                    seen = 1'b1;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no result pending");
                    end else begin
                        check("latency", 32'(cyc_cnt - sb[0].hs), 32'd17);
                    end
                end
                if (rsp_valid && rsp_ready) begin
                    seen = 1'b0;
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("rsp_sum", {16'd0, rsp_sum}, {16'd0, e.sum});
                        check("rsp_cout", {31'd0, rsp_cout}, {31'd0, e.cout});
                        check("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, e.ovf});
                    end
                end
            end
        end
    end

    // Phase / operand monitor: steps last 2 cycles, phase k high on steps k and k+1.
    initial begin
        int rel, stp;
        logic [7:0] act_pos, act_neg, exp_pos, a_now, dummy;
        logic [15:0] a_v, b_v;
        forever begin
            @(negedge clk);
            rel = cyc_cnt - cur_hs - 1;
            stp = rel / 2;
            for (int k = 0; k < 8; k++) begin
                act_pos[k] = clkpos[k];
                act_neg[k] = clkneg[k];
                exp_pos[k] = (rel >= 0) && (rel <= 17) && ((stp == k) || (stp == k + 1));
            end
            check("clkneg_compl", {24'd0, act_neg}, {24'd0, ~act_pos});
            check("clkpos", {24'd0, act_pos}, {24'd0, exp_pos});
            if (rel >= 0 && rel <= 17) begin
                for (int i = 0; i < 16; i++) begin
                    a_v[i] = add_a[i];
                    b_v[i] = add_b[i];
                end
                check("add_a_stable", {16'd0, a_v}, {16'd0, cur_a});
                check("add_b_stable", {16'd0, b_v}, {16'd0, cur_b});
                check("add_cin_stable", {31'd0, add_cin}, {31'd0, cur_cin});
            end
            a_now = '0;
            dummy = a_now;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the launch edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input logic [15:0] esum, input logic ecout,
                         input logic eovf, input logic [15:0] eb, input logic ecin);
        int n;
        exp_t e;
        logic [15:0] b_v;
        n = 0;
        req_a = a; req_b = b; req_cin = cin; req_sub = sub; req_valid = 1'b1;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got req_ready=0 expected 1 within 100 cycles");
        end else begin
            e.sum = esum; e.cout = ecout; e.ovf = eovf; e.hs = cyc_cnt;
            sb.push_back(e);
            prev_hs = cur_hs;
            cur_hs = cyc_cnt;
            cur_a = a; cur_b = eb; cur_cin = ecin;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) b_v[i] = add_b[i];
        check("launch_add_b", {16'd0, b_v}, {16'd0, eb});
        check("launch_add_cin", {31'd0, add_cin}, {31'd0, ecin});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_cin = 1'b0; req_sub = 1'b0;
        @(negedge clk);
        check("rst_clkpos", {24'd0, clkpos}, 32'h00);
        check("rst_clkneg", {24'd0, clkneg}, 32'hFF);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_sum", {16'd0, rsp_sum}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 16'h0001, 1'b0);
        drain();

        // Wrap-around, then overflow, issued back-to-back.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 16'h0001, 1'b0);
        check("back_to_back_gap", 32'(cur_hs - prev_hs), 32'd19);
        drain();

        // Subtract ignores req_cin.
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16'hFFF8, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16'hFFFE, 1'b1);
        drain();

        // Backpressure on the result.
        rsp_ready = 1'b0;
        issue(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 16'h4321, 1'b1);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            check("bp_rsp_sum", {16'd0, rsp_sum}, 32'h5556);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        #1;
        check("bp_release_req_ready", {31'd0, req_ready}, 32'd1);
        drain();

        // Reset during step 4 discards the in-flight operation.
        issue(16'h00FF, 16'h0F0F, 1'b0, 1'b0, 16'h100E, 1'b0, 1'b0, 16'h0F0F, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_clkpos", {24'd0, clkpos}, 32'h18);
        #1;
        rst = 1'b1;
        cur_hs = -1000;
        sb.delete();
        #1;
        check("midrst_clkpos", {24'd0, clkpos}, 32'h00);
        check("midrst_clkneg", {24'd0, clkneg}, 32'hFF);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);

        issue(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
